// File: rtl/clock_switch_ctrl.sv
// Glitch-free clock switch sequencer: select gap, settle, commit, with abort back to the committed clock.
// Switch takes 2*WAIT_CYCLES clk cycles; requests are taken only in IDLE (req_ready), ignored while busy.
module clock_switch_ctrl #(
  parameter int N           = 2,
  parameter int WAIT_CYCLES = 8,
  parameter int DEFAULT_SEL = 0,
  localparam int W          = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic [W-1:0] req_idx,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] clk_ok,
  output logic [N-1:0] select,
  output logic [W-1:0] cur_idx,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int CW = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [W-1:0]  DEF_IDX  = W'(DEFAULT_SEL);

  typedef enum logic [1:0] {IDLE, GAP, SETTLE} state_t;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] i);
    return {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   target_q, target_d;
  logic [W-1:0]   cur_idx_q, cur_idx_d;
  logic [N-1:0]   select_q, select_d;
  logic           abort_q, abort_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           req_ok;
  logic           tgt_lost;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      target_q  <= DEF_IDX;
      cur_idx_q <= DEF_IDX;
      select_q  <= onehot(DEF_IDX);
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      cur_idx_q <= cur_idx_d;
      select_q  <= select_d;
      abort_q   <= abort_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    cur_idx_d = cur_idx_q;
    select_d  = select_q;
    abort_d   = abort_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    req_ok   = (int'(req_idx) < N) && clk_ok[req_idx];
    // Once retreating to the committed clock, losing it again must not restart the sequence.
    tgt_lost = (target_q != cur_idx_q) && !clk_ok[target_q];

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!req_ok) begin
            err_d = 1'b1;
          end else if (req_idx == cur_idx_q) begin
            done_d = 1'b1;
          end else begin
            target_d = req_idx;
            abort_d  = 1'b0;
            select_d = '0;
            cnt_d    = CNT_LOAD;
            state_d  = GAP;
          end
        end
      end
      GAP, SETTLE: begin
        if (tgt_lost) begin
          target_d = cur_idx_q;
          abort_d  = 1'b1;
          select_d = '0;
          cnt_d    = CNT_LOAD;
          state_d  = GAP;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (state_q == GAP) begin
          select_d = onehot(target_q);
          cnt_d    = CNT_LOAD;
          state_d  = SETTLE;
        end else begin
          cur_idx_d = target_q;
          done_d    = !abort_q;
          err_d     = abort_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign select    = select_q;
  assign cur_idx   = cur_idx_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Bench for clock_switch_ctrl: elapsed-time reference model checked every cycle, plus pinned scenarios.
module tb_clock_switch_ctrl;

  localparam int N   = 2;
  localparam int WC  = 8;
  localparam int DEF = 0;
  localparam int W   = 1;

  logic         clk;
  logic         rstb;
  logic [W-1:0] req_idx;
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] clk_ok;
  logic [N-1:0] select;
  logic [W-1:0] cur_idx;
  logic         busy;
  logic         done;
  logic         err;

  int n_cmp;
  int n_bad;

  clock_switch_ctrl #(.N(N), .WAIT_CYCLES(WC), .DEFAULT_SEL(DEF)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .req_idx   (req_idx),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .clk_ok    (clk_ok),
    .select    (select),
    .cur_idx   (cur_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a switch is just "cycles elapsed since (re)start"; select is dark for the first WC of them.
  logic m_busy;
  int   m_cur;
  int   m_tgt;
  logic m_ab;
  int   m_t;
  logic m_done;
  logic m_err;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_busy <= 1'b0;
      m_cur  <= DEF;
      m_tgt  <= DEF;
      m_ab   <= 1'b0;
      m_t    <= 0;
      m_done <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (!m_busy) begin
        if (req_valid) begin
          if (int'(req_idx) >= N || !clk_ok[req_idx]) m_err <= 1'b1;
          else if (int'(req_idx) == m_cur) m_done <= 1'b1;
          else begin
            m_busy <= 1'b1;
            m_tgt  <= int'(req_idx);
            m_ab   <= 1'b0;
            m_t    <= 0;
          end
        end
      end else if (m_tgt != m_cur && !clk_ok[m_tgt]) begin
        m_tgt <= m_cur;
        m_ab  <= 1'b1;
        m_t   <= 0;
      end else if (m_t == 2*WC - 1) begin
        m_busy <= 1'b0;
        m_cur  <= m_tgt;
        if (m_ab) m_err <= 1'b1;
        else      m_done <= 1'b1;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  function automatic logic [N-1:0] m_sel();
    logic [N-1:0] v;
    v = '0;
    if (!m_busy)       v[m_cur] = 1'b1;
    else if (m_t >= WC) v[m_tgt] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("select",    32'(select),    32'(m_sel()));
    chk("cur_idx",   32'(cur_idx),   32'(m_cur));
    chk("req_ready", 32'(req_ready), 32'(!m_busy));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("done",      32'(done),      32'(m_done));
    chk("err",       32'(err),       32'(m_err));
    chk("sel_onehot", 32'($countones(select) <= 1), 32'(1));
    chk("done_err_excl", 32'(done & err), 32'(0));
  endtask

  // One clock: inputs already set, let the edge happen, check at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rstb      = 1'b0;
    req_valid = 1'b0;
    req_idx   = '0;
    clk_ok    = 2'b11;
    repeat (3) tick();
    chk("rst_select", 32'(select), 32'h1);
    chk("rst_cur",    32'(cur_idx), 32'h0);
    chk("rst_ready",  32'(req_ready), 32'h1);
    chk("rst_busy",   32'(busy), 32'h0);
    rstb = 1'b1;
    tick();

    // Clean 0->1 switch
    req_valid = 1'b1; req_idx = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i <= 2*WC; i++) begin
      if (i > 0) tick();
      chk("sw01_select", 32'(select), (i < WC) ? 32'h0 : 32'h2);
      chk("sw01_done",   32'(done), 32'(i == 2*WC));
    end
    chk("sw01_cur", 32'(cur_idx), 32'h1);

    // Same-index request while on clock 1
    req_valid = 1'b1; req_idx = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("same1_done",   32'(done), 32'h1);
    chk("same1_select", 32'(select), 32'h2);
    tick();
    chk("same1_done_clr", 32'(done), 32'h0);

    // Back to clock 0
    req_valid = 1'b1; req_idx = 1'b0;
    tick();
    req_valid = 1'b0;
    repeat (2*WC + 1) tick();
    chk("sw10_cur", 32'(cur_idx), 32'h0);

    // Reject: target clock not present
    clk_ok = 2'b01;
    req_valid = 1'b1; req_idx = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rej_err",    32'(err), 32'h1);
    chk("rej_select", 32'(select), 32'h1);
    chk("rej_ready",  32'(req_ready), 32'h1);
    tick();
    chk("rej_err_clr", 32'(err), 32'h0);
    clk_ok = 2'b11;

    // Same-index request on clock 0: select never drops
    req_valid = 1'b1; req_idx = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("same0_done",   32'(done), 32'h1);
    chk("same0_select", 32'(select), 32'h1);

    // Abort: clock 1 lost during SETTLE
    req_valid = 1'b1; req_idx = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= WC + 2; i++) tick();
    chk("ab_settle_sel", 32'(select), 32'h2);
    clk_ok = 2'b01;
    for (int j = 0; j <= 2*WC; j++) begin
      tick();
      chk("ab_select", 32'(select), (j < WC) ? 32'h0 : 32'h1);
      chk("ab_err",    32'(err), 32'(j == 2*WC));
      chk("ab_done",   32'(done), 32'h0);
    end
    chk("ab_cur", 32'(cur_idx), 32'h0);
    clk_ok = 2'b11;
    tick();

    // Reset mid-GAP
    req_valid = 1'b1; req_idx = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    chk("midgap_select", 32'(select), 32'h0);
    rstb = 1'b0;
    #1;
    chk("rstgap_select", 32'(select), 32'h1);
    chk("rstgap_cur",    32'(cur_idx), 32'h0);
    chk("rstgap_busy",   32'(busy), 32'h0);
    compare_all();
    tick();
    rstb = 1'b1;
    for (int i = 0; i < 2*WC + 2; i++) begin
      tick();
      chk("rstgap_nopulse", 32'({done, err}), 32'h0);
    end

    // req_valid held with alternating index
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req_idx = W'(i & 1);
      tick();
    end
    req_valid = 1'b0;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_idx   = W'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0)
        clk_ok = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      rstb = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_switch_ctrl.md
CLOCK_SWITCH_CTRL -- requirements
Module: clock_switch_ctrl

Interface
REQ-001 SHALL have parameter N, default 2: number of selectable clocks, legal range 2..16.
REQ-002 SHALL have parameter WAIT_CYCLES, default 8: settle time in clk cycles for each switch phase, minimum 1.
REQ-003 SHALL have parameter DEFAULT_SEL, default 0: clock index selected out of reset, range 0..N-1.
REQ-004 SHALL define W = max(1, clog2(N)) as the width of every index port.
REQ-005 SHALL have port clk, input, 1 bit: always-on controller clock; single clock domain.
REQ-006 SHALL have port rstb, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port req_idx, input, W bits: requested clock index.
REQ-008 SHALL have port req_valid, input, 1 bit: request qualifier.
REQ-009 SHALL have port req_ready, output, 1 bit: controller can accept a request.
REQ-010 SHALL have port clk_ok, input, N bits: per-clock "present and stable" flags, already synchronous to clk.
REQ-011 SHALL have port select, output, N bits: one-hot or all-zero select vector, driven to the clock_mux select input.
REQ-012 SHALL have port cur_idx, output, W bits: index of the currently committed clock.
REQ-013 SHALL have port busy, output, 1 bit: a switch sequence is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse on a rejected or aborted request.

Function
REQ-016 SHALL implement the states IDLE, GAP and SETTLE, with a down-counter cnt of width clog2(WAIT_CYCLES)+1.
REQ-017 SHALL drive req_ready = (state == IDLE) and busy = (state != IDLE), both combinational from state.
REQ-018 SHALL accept a request on a rising clk edge at which req_valid and req_ready are both 1; req_idx is sampled at that edge only.
REQ-019 SHALL reject an accepted request with req_idx >= N or clk_ok[req_idx] == 0: err = 1 for the next cycle; state, select and cur_idx unchanged.
REQ-020 SHALL complete an accepted request with req_idx == cur_idx and clk_ok true without switching: done = 1 for the next cycle; state stays IDLE.
REQ-021 SHALL, for any other accepted request, at the accept edge: latch target = req_idx, clear abort, set select = 0, load cnt = WAIT_CYCLES-1 and enter GAP.
REQ-022 SHALL, in GAP, decrement cnt each edge; at the edge where cnt == 0 it SHALL set select = onehot(target), reload cnt = WAIT_CYCLES-1 and enter SETTLE.
REQ-023 SHALL, in SETTLE, decrement cnt each edge; at the edge where cnt == 0 it SHALL set cur_idx = target and pulse done (abort = 0) or err (abort = 1), then enter IDLE.
REQ-024 SHALL produce this timing for a clean switch accepted at edge k: select all-zero from k to k+WAIT_CYCLES, new select from k+WAIT_CYCLES, done high in the cycle following edge k+2*WAIT_CYCLES.
REQ-025 SHALL handle clk_ok[target] == 0 at any GAP or SETTLE edge while target != cur_idx as follows: target = cur_idx, abort = 1, select = 0, cnt = WAIT_CYCLES-1 and enter GAP (restart toward the old clock).
REQ-026 SHALL NOT let an abort toward the committed clock (target == cur_idx) trigger a further abort; the sequence SHALL run to completion.
REQ-027 SHALL never assert more than one select bit, and SHALL never drive select non-zero in GAP.
REQ-028 SHALL ignore req_valid while busy; a request held across busy SHALL be accepted at the first IDLE edge.
REQ-029 SHALL never assert done and err in the same cycle.

Reset
REQ-030 SHALL, while rstb is 0: state = IDLE, cnt = 0, target = DEFAULT_SEL, abort = 0, select = onehot(DEFAULT_SEL), cur_idx = DEFAULT_SEL, done = 0, err = 0.
REQ-031 SHALL treat reset asserted mid-sequence as immediate: outputs return to the reset values of REQ-030 with no partial completion pulse.

Verification
REQ-032 SHALL cover: N=2, W_C=8, reset release, then request idx 1 with clk_ok=11 -> select 01, then 00 for 8 cycles, then 10; done after 16 cycles; cur_idx=1.
REQ-033 SHALL cover: request idx 3 with N=2, or request idx 1 with clk_ok=01 -> err pulse 1 cycle after accept; select stays 01; req_ready stays 1.
REQ-034 SHALL cover: request idx 0 while cur_idx=0 -> done pulse next cycle; select never drops to 00.
REQ-035 SHALL cover: switch 0->1 with clk_ok[1] dropped at SETTLE cycle 3 -> select 00 for 8 cycles, then 01; err pulse; cur_idx=0; done never pulses.
REQ-036 SHALL cover: rstb pulsed low mid-GAP of a 0->1 switch -> select=01, cur_idx=0 and busy=0 immediately; no done or err pulse.
REQ-037 SHALL cover: req_valid held high for 40 cycles with alternating req_idx -> each accept only when req_ready=1; a checker confirms at most one select bit is high every cycle.
